dsp_equation_engine: RTL and testbench
======================================

Name: dsp_equation_engine

Overview:
- Parametrised successor to the single-equation sum engine in the DSP equations block.
- Streams N signed samples from a file-backed source channel over the file handshake and evaluates one of six runtime-selected equations: SUM, MIN, MAX, MEAN, SUMSQ or SCALE.
- SCALE writes a transformed stream to a destination file channel.
- Results and status are returned through the dsp_output registers.

Parameters:
- DW, 32: sample and register width.
- ACC_W, 64: accumulator width; must satisfy 2*DW <= ACC_W <= 2*DW.
- TIMEOUT, 1024: maximum cycles to wait for file_active per transfer.
- SATURATE, 1: 1 = clamp on overflow; 0 = wrap and flag error.

Ports:
- wb_clk  in  1  clock.
- wb_rst  in  1  asynchronous reset, active-high.
- dsp_input0_reg  in  DW  control: [0] start, [3:1] mode, [15:8] src file, [23:16] dst file.
- dsp_input1_reg  in  DW  sample count N.
- dsp_input2_reg  in  DW  [5:0] shift amount, used by MEAN and SCALE.
- dsp_input3_reg  in  DW  signed coefficient, used by SCALE.
- dsp_output0_reg  out  DW  result[DW-1:0].
- dsp_output1_reg  out  DW  result[ACC_W-1:DW].
- dsp_output2_reg  out  DW  samples processed.
- dsp_output3_reg  out  DW  status: [0] busy, [1] done, [2] error, [5:3] error code.
- done  out  1  level; high from completion until the next start.
- interrupt  out  1  one-cycle pulse on completion or error.
- error  out  1  sticky until next start.
- file_num  out  8  active file channel.
- file_read  out  1  read request.
- file_write  out  1  write request.
- file_write_data  out  32  write data.
- file_read_data  in  32  read data; valid when file_active is high.
- file_active  in  1  one-cycle acknowledge.

Behaviour:
- Reset: all outputs 0; state IDLE; accumulator, counters and edge register cleared.
- Reset mid-operation aborts immediately with no further requests.
- Start: a rising edge on dsp_input0_reg[0] in IDLE, DONE or ERR latches mode, files, N, shift and coefficient.
- On start: clear done, error and counters; enter CHECK.
- A start edge while busy is ignored.
- CHECK errors (one cycle):
  - N == 0: code 1.
  - mode > 5: code 2.
- Otherwise the accumulator initialises as follows:
  - SUM, MEAN, SUMSQ: 0.
  - MIN: most positive value.
  - MAX: most negative value.
- CHECK then proceeds to RD.
- RD: drive file_num = src and file_read = 1.
- Read handshake: the cycle file_active = 1, capture file_read_data[DW-1:0] as signed x and drop file_read the next cycle.
- Timeout: a per-transfer counter that reaches TIMEOUT enters ERR with code 3.
- Read then goes to ACC (one cycle). SCALE goes to WR instead.
- ACC updates by mode:
  - SUM / MEAN: acc += sign-extended x.
  - SUMSQ: acc += x*x.
  - MIN / MAX: signed compare, update acc.
- SCALE: y = (x*coef) >>> shift, clamped to the signed DW range.
- WR: file_num = dst, file_write = 1, file_write_data = y. Drop the request after the file_active cycle; timeout gives code 3.
- Overflow: detected on sign of operands vs. sign of sum at ACC_W.
  - SATURATE = 1: clamp to the ACC_W extreme.
  - SATURATE = 0: wrap, set error with code 4, and continue.
- count++ after each ACC or WR. If count == N go to FIN, else go back to RD.
- FIN:
  - MEAN: result = acc >>> shift (arithmetic).
  - SCALE: result = count.
  - All other modes: result = acc.
- FIN then sets done = 1, pulses interrupt, and goes to DONE.
- ERR: error = 1, interrupt pulse, done = 0, and all requests are dropped the same cycle.
- file_read and file_write are never both high. Requests are held until acknowledged.
- file_active arriving with no request outstanding is ignored.
- Status bit busy = 1 in every state except IDLE, DONE and ERR.

Test Plan:
- SUM, N = 4, samples {1, 2, 3, -10} -> output0 = 0xFFFFFFFC, output1 = 0xFFFFFFFF, output2 = 4, done = 1, one interrupt pulse.
- MIN and MAX, N = 3, samples {5, -7, 2} -> MIN result = -7, MAX result = 5.
- MEAN, shift = 2, samples {4, 8, 12, 16} -> result = 10.
- SUMSQ, samples {3, 4} -> result = 25.
- SCALE, coef = 3, shift = 1, samples {10, 0x7FFFFFFF} -> writes 15 then 0x7FFFFFFF to dst file; result = 2.
- Error cases:
  - N = 0 -> error code 1.
  - mode = 7 -> error code 2.
  - file_active withheld for 1024 cycles -> error code 3 with file_read dropped.
  - SATURATE = 0 with MAX-plus-1 accumulation -> error code 4 and wrapped result.
- Reset asserted during WR -> all outputs 0 next cycle; a subsequent start runs cleanly.

Source files
------------

// File: rtl/dsp_equation_engine.sv
// rtl/dsp_equation_engine.sv - streaming SUM/MIN/MAX/MEAN/SUMSQ/SCALE engine over the file handshake
module dsp_equation_engine #(
   parameter int DW       = 32,
   parameter int ACC_W    = 64,
   parameter int TIMEOUT  = 1024,
   parameter int SATURATE = 1
)(
   input  logic          wb_clk,
   input  logic          wb_rst,
   input  logic [DW-1:0] dsp_input0_reg,
   input  logic [DW-1:0] dsp_input1_reg,
   input  logic [DW-1:0] dsp_input2_reg,
   input  logic [DW-1:0] dsp_input3_reg,
   output logic [DW-1:0] dsp_output0_reg,
   output logic [DW-1:0] dsp_output1_reg,
   output logic [DW-1:0] dsp_output2_reg,
   output logic [DW-1:0] dsp_output3_reg,
   output logic          done,
   output logic          interrupt,
   output logic          error,
   output logic [7:0]    file_num,
   output logic          file_read,
   output logic          file_write,
   output logic [31:0]   file_write_data,
   input  logic [31:0]   file_read_data,
   input  logic          file_active
);

   localparam logic [2:0] M_SUM = 3'd0, M_MIN = 3'd1, M_MAX = 3'd2,
                          M_MEAN = 3'd3, M_SUMSQ = 3'd4, M_SCALE = 3'd5;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
   localparam logic signed [2*DW-1:0] Y_MAX = {{(DW+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [2*DW-1:0] Y_MIN = {{(DW+1){1'b1}}, {(DW-1){1'b0}}};

   typedef enum logic [2:0] {IDLE, CHECK, RD, ACC, WR, FIN, DONE, ERR} state_t;
   state_t state, state_nxt;

   logic                    start_q, done_q, irq_q, err_q;
   logic [2:0]              mode_q, code_q, code_nxt;
   logic [7:0]              src_q, dst_q;
   logic [DW-1:0]           n_q, count_q;
   logic [5:0]              shift_q;
   logic signed [DW-1:0]    coef_q, x_q;
   logic signed [ACC_W-1:0] acc_q, result_q;
   logic [TW-1:0]           tmo_q;

   logic                    start_edge, last, tmo_hit, busy, ovf;
   logic signed [ACC_W-1:0] x_ext, addend, sum, acc_sat;
   logic signed [2*DW-1:0]  sq, prod, shifted;
   logic [DW-1:0]           y;
   logic                    unused_ok;

   assign unused_ok  = ^{dsp_input0_reg[DW-1:24], dsp_input0_reg[7:4], dsp_input2_reg[DW-1:6]};
   assign start_edge = dsp_input0_reg[0] & ~start_q;
   assign last       = (count_q + DW'(1)) == n_q;
   assign tmo_hit    = tmo_q == TW'(TIMEOUT - 1);
   assign busy       = !(state == IDLE || state == DONE || state == ERR);

   // Overflow: both operands share a sign that the sum does not.
   always_comb begin
      x_ext   = {{(ACC_W-DW){x_q[DW-1]}}, x_q};
      sq      = x_q * x_q;
      addend  = (mode_q == M_SUMSQ) ? sq : x_ext;
      sum     = acc_q + addend;
      ovf     = (acc_q[ACC_W-1] == addend[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);
      acc_sat = acc_q[ACC_W-1] ? ACC_MIN : ACC_MAX;
      prod    = x_q * coef_q;
      shifted = prod >>> shift_q;
      if (shifted > Y_MAX)      y = Y_MAX[DW-1:0];
      else if (shifted < Y_MIN) y = Y_MIN[DW-1:0];
      else                      y = shifted[DW-1:0];
   end

   always_ff @(posedge wb_clk or posedge wb_rst) begin
      if (wb_rst) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      code_nxt  = 3'd0;
      case (state)
         IDLE, DONE, ERR: if (start_edge) state_nxt = CHECK;
         CHECK: begin
            if (n_q == '0) begin
               state_nxt = ERR;
               code_nxt  = 3'd1;
            end else if (mode_q > M_SCALE) begin
               state_nxt = ERR;
               code_nxt  = 3'd2;
            end else begin
               state_nxt = RD;
            end
         end
         RD: begin
            if (file_active) state_nxt = (mode_q == M_SCALE) ? WR : ACC;
            else if (tmo_hit) begin
               state_nxt = ERR;
               code_nxt  = 3'd3;
            end
         end
         ACC: state_nxt = last ? FIN : RD;
         WR: begin
            if (file_active) state_nxt = last ? FIN : RD;
            else if (tmo_hit) begin
               state_nxt = ERR;
               code_nxt  = 3'd3;
            end
         end
         FIN:     state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk or posedge wb_rst) begin
      if (wb_rst) begin
         start_q  <= 1'b0;
         done_q   <= 1'b0;
         irq_q    <= 1'b0;
         err_q    <= 1'b0;
         mode_q   <= '0;
         code_q   <= '0;
         src_q    <= '0;
         dst_q    <= '0;
         n_q      <= '0;
         count_q  <= '0;
         shift_q  <= '0;
         coef_q   <= '0;
         x_q      <= '0;
         acc_q    <= '0;
         result_q <= '0;
         tmo_q    <= '0;
      end else begin
         start_q <= dsp_input0_reg[0];
         irq_q   <= 1'b0;
         if (state != state_nxt)          tmo_q <= '0;
         else if (state == RD || state == WR) tmo_q <= tmo_q + TW'(1);

         case (state)
            IDLE, DONE, ERR: begin
               if (start_edge) begin
                  mode_q  <= dsp_input0_reg[3:1];
                  src_q   <= dsp_input0_reg[15:8];
                  dst_q   <= dsp_input0_reg[23:16];
                  n_q     <= dsp_input1_reg;
                  shift_q <= dsp_input2_reg[5:0];
                  coef_q  <= dsp_input3_reg;
                  done_q  <= 1'b0;
                  err_q   <= 1'b0;
                  code_q  <= '0;
                  count_q <= '0;
               end
            end
            CHECK: begin
               case (mode_q)
                  M_MIN:   acc_q <= ACC_MAX;
                  M_MAX:   acc_q <= ACC_MIN;
                  default: acc_q <= '0;
               endcase
            end
            RD: if (file_active) x_q <= file_read_data[DW-1:0];
            ACC: begin
               count_q <= count_q + DW'(1);
               case (mode_q)
                  M_MIN: if (x_ext < acc_q) acc_q <= x_ext;
                  M_MAX: if (x_ext > acc_q) acc_q <= x_ext;
                  default: begin
                     if (!ovf) acc_q <= sum;
                     else if (SATURATE != 0) acc_q <= acc_sat;
                     else begin
                        acc_q  <= sum;
                        err_q  <= 1'b1;
                        code_q <= 3'd4;
                     end
                  end
               endcase
            end
            WR: if (file_active) count_q <= count_q + DW'(1);
            FIN: begin
               case (mode_q)
                  M_MEAN:  result_q <= acc_q >>> shift_q;
                  M_SCALE: result_q <= {{(ACC_W-DW){1'b0}}, count_q};
                  default: result_q <= acc_q;
               endcase
               done_q <= 1'b1;
               irq_q  <= 1'b1;
            end
            default: ;
         endcase

         if (state_nxt == ERR && state != ERR) begin
            err_q  <= 1'b1;
            code_q <= code_nxt;
            irq_q  <= 1'b1;
            done_q <= 1'b0;
         end
      end
   end

   always_comb begin
      file_num        = '0;
      file_read       = 1'b0;
      file_write      = 1'b0;
      file_write_data = '0;
      if (state == RD) begin
         file_num  = src_q;
         file_read = 1'b1;
      end else if (state == WR) begin
         file_num        = dst_q;
         file_write      = 1'b1;
         file_write_data = 32'(y);
      end
   end

   assign dsp_output0_reg = result_q[DW-1:0];
   assign dsp_output1_reg = result_q[ACC_W-1:DW];
   assign dsp_output2_reg = count_q;
   assign dsp_output3_reg = {{(DW-6){1'b0}}, code_q, err_q, done_q, busy};
   assign done            = done_q;
   assign error           = err_q;
   assign interrupt       = irq_q;

endmodule

// File: tb/tb_dsp_equation_engine.sv
// tb/tb_dsp_equation_engine.sv - directed-vector bench for dsp_equation_engine
module tb_dsp_equation_engine;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] in0, in1, in2, in3;
   logic [31:0] file_read_data;
   logic        file_active;

   logic [31:0] out0, out1, out2, out3, file_write_data;
   logic        done, interrupt, error, file_read, file_write;
   logic [7:0]  file_num;

   logic [31:0] w_out0, w_out1, w_out2, w_out3, w_wdata;
   logic        w_done, w_irq, w_error, w_read, w_write;
   logic [7:0]  w_num;

   int n_checks = 0, n_errors = 0;
   int rd_idx = 0, wr_cnt = 0, irq_cnt = 0, wait_cnt = 0;
   int stray_req = 0, stray_done = 0;
   bit withhold = 1'b0;
   logic [31:0] src_mem [0:63];
   logic [31:0] wr_log  [0:63];

   always #5 clk = ~clk;

   dsp_equation_engine #(.SATURATE(1)) dut (
      .wb_clk(clk), .wb_rst(rst),
      .dsp_input0_reg(in0), .dsp_input1_reg(in1), .dsp_input2_reg(in2), .dsp_input3_reg(in3),
      .dsp_output0_reg(out0), .dsp_output1_reg(out1), .dsp_output2_reg(out2), .dsp_output3_reg(out3),
      .done(done), .interrupt(interrupt), .error(error), .file_num(file_num),
      .file_read(file_read), .file_write(file_write), .file_write_data(file_write_data),
      .file_read_data(file_read_data), .file_active(file_active)
   );

   // Wrapping twin sees identical stimulus; its handshake timing matches dut exactly.
   dsp_equation_engine #(.SATURATE(0)) dut_wrap (
      .wb_clk(clk), .wb_rst(rst),
      .dsp_input0_reg(in0), .dsp_input1_reg(in1), .dsp_input2_reg(in2), .dsp_input3_reg(in3),
      .dsp_output0_reg(w_out0), .dsp_output1_reg(w_out1), .dsp_output2_reg(w_out2), .dsp_output3_reg(w_out3),
      .done(w_done), .interrupt(w_irq), .error(w_error), .file_num(w_num),
      .file_read(w_read), .file_write(w_write), .file_write_data(w_wdata),
      .file_read_data(file_read_data), .file_active(file_active)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // File channel model: acknowledges each request after one idle cycle.
   initial begin
      file_active    = 1'b0;
      file_read_data = '0;
      forever begin
         @(negedge clk);
         file_active = 1'b0;
         if (!withhold && (file_read || file_write)) begin
            if (wait_cnt < 1) wait_cnt++;
            else begin
               wait_cnt    = 0;
               file_active = 1'b1;
               if (file_read) begin
                  file_read_data = src_mem[rd_idx];
                  rd_idx++;
               end else begin
                  wr_log[wr_cnt] = file_write_data;
                  wr_cnt++;
               end
            end
         end else if (!file_read && !file_write && stray_req != stray_done) begin
            file_active = 1'b1;
            stray_done++;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (interrupt) irq_cnt++;
      end
   end

   task automatic put(input int i, input logic [31:0] v);
      src_mem[rd_idx + i] = v;
   endtask

   task automatic run_op(input logic [2:0] mode, input logic [31:0] n,
                         input logic [5:0] sh, input logic [31:0] coef);
      int cyc;
      @(negedge clk);
      in0 = {8'd0, 8'd9, 8'd5, 4'd0, mode, 1'b0};
      in1 = n;
      in2 = {26'd0, sh};
      in3 = coef;
      @(negedge clk);
      in0[0] = 1'b1;
      @(negedge clk);
      in0[0] = 1'b0;
      cyc = 0;
      while (!done && !error && cyc < 3000) begin
         @(negedge clk);
         cyc++;
      end
      check("op_finished", {63'd0, (done | error)}, 64'd1);
      @(negedge clk);
   endtask

   initial begin
      int irq0, wr0, cyc;
      rst = 1'b1;
      in0 = '0; in1 = '0; in2 = '0; in3 = '0;
      repeat (3) @(negedge clk);
      check("reset_outputs", {63'd0, |{out0, out1, out2, out3, done, interrupt, error,
                                       file_num, file_read, file_write, file_write_data}}, 64'd0);
      rst = 1'b0;

      // SUM {1,2,3,-10}
      put(0, 32'd1); put(1, 32'd2); put(2, 32'd3); put(3, 32'hFFFF_FFF6);
      irq0 = irq_cnt;
      run_op(3'd0, 32'd4, 6'd0, 32'd0);
      check("sum_out0", out0, 64'hFFFF_FFFC);
      check("sum_out1", out1, 64'hFFFF_FFFF);
      check("sum_count", out2, 64'd4);
      check("sum_status", out3, 64'h2);
      check("sum_done", {63'd0, done}, 64'd1);
      check("sum_irq_pulses", irq_cnt - irq0, 64'd1);

      // MIN / MAX {5,-7,2}
      put(0, 32'd5); put(1, 32'hFFFF_FFF9); put(2, 32'd2);
      run_op(3'd1, 32'd3, 6'd0, 32'd0);
      check("min_result", {out1, out0}, 64'hFFFF_FFFF_FFFF_FFF9);
      put(0, 32'd5); put(1, 32'hFFFF_FFF9); put(2, 32'd2);
      run_op(3'd2, 32'd3, 6'd0, 32'd0);
      check("max_result", {out1, out0}, 64'd5);

      // MEAN shift 2 {4,8,12,16}
      put(0, 32'd4); put(1, 32'd8); put(2, 32'd12); put(3, 32'd16);
      run_op(3'd3, 32'd4, 6'd2, 32'd0);
      check("mean_result", {out1, out0}, 64'd10);

      // SUMSQ {3,4}
      put(0, 32'd3); put(1, 32'd4);
      run_op(3'd4, 32'd2, 6'd0, 32'd0);
      check("sumsq_result", {out1, out0}, 64'd25);

      // SCALE coef 3 shift 1 {10, 0x7FFFFFFF}
      put(0, 32'd10); put(1, 32'h7FFF_FFFF);
      wr0 = wr_cnt;
      run_op(3'd5, 32'd2, 6'd1, 32'd3);
      check("scale_writes", wr_cnt - wr0, 64'd2);
      check("scale_wr0", wr_log[wr0], 64'd15);
      check("scale_wr1", wr_log[wr0 + 1], 64'h7FFF_FFFF);
      check("scale_result", {out1, out0}, 64'd2);

      // Error: N = 0, mode = 7
      run_op(3'd0, 32'd0, 6'd0, 32'd0);
      check("n0_status", out3, 64'h0C);
      check("n0_done", {63'd0, done}, 64'd0);
      run_op(3'd7, 32'd1, 6'd0, 32'd0);
      check("mode7_status", out3, 64'h14);

      // Error: read never acknowledged
      withhold = 1'b1;
      run_op(3'd0, 32'd1, 6'd0, 32'd0);
      check("timeout_status", out3, 64'h1C);
      check("timeout_read_low", {63'd0, file_read}, 64'd0);
      withhold = 1'b0;

      // Accumulator overflow: 2^62 + 2^62
      put(0, 32'h8000_0000); put(1, 32'h8000_0000);
      run_op(3'd4, 32'd2, 6'd0, 32'd0);
      check("sat_result", {out1, out0}, 64'h7FFF_FFFF_FFFF_FFFF);
      check("sat_error", {63'd0, error}, 64'd0);
      check("wrap_result", {w_out1, w_out0}, 64'h8000_0000_0000_0000);
      check("wrap_status", w_out3, 64'h26);

      // Reset during WR, then a clean run
      put(0, 32'd1); put(1, 32'd2);
      @(negedge clk);
      in0 = {8'd0, 8'd9, 8'd5, 4'd0, 3'd5, 1'b0}; in1 = 32'd2; in2 = '0; in3 = 32'd1;
      @(negedge clk); in0[0] = 1'b1;
      @(negedge clk); in0[0] = 1'b0;
      cyc = 0;
      while (!file_write && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      check("saw_write", {63'd0, file_write}, 64'd1);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_outputs", {63'd0, |{out0, out1, out2, out3, done, interrupt, error,
                                         file_num, file_read, file_write, file_write_data}}, 64'd0);
      rst = 1'b0;
      put(0, 32'd7);
      run_op(3'd0, 32'd1, 6'd0, 32'd0);
      check("post_rst_result", {out1, out0}, 64'd7);

      // Stray acknowledge in DONE is ignored
      stray_req++;
      repeat (3) @(negedge clk);
      check("stray_count", out2, 64'd1);
      check("stray_status", out3, 64'h2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
